inmf_sdp_buf: RTL and testbench

//  Parametrised single-clock simple dual-port buffer (1 write port, 1 read port) for the INMF datapath.

---
 rtl/inmf_pkg.sv | 19 +
 rtl/inmf_sdp_core.sv | 38 +++
 rtl/inmf_sdp_buf.sv | 137 +++++++++++++
 tb/tb_inmf_sdp_buf.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/inmf_pkg.sv
// Shared types and helpers for the INMF simple dual-port buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inmf_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } inmf_buf_st_t;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;

    // Number of words addressed by an addr_w-bit address.
    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/inmf_sdp_core.sv
// Inferred block-RAM array: synchronous write, registered read, write-first bypass.
// Latency: q updates on the edge that samples re (one cycle).
// Backpressure: none; one write and one read accepted every cycle.
module inmf_sdp_core
    import inmf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [depth(ADDR_W)];

    // Storage array is deliberately not reset; the sweep FSM zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-address write in the same cycle wins, and q holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/inmf_sdp_buf.sv
// INMF simple dual-port buffer with valid-tagged read pipeline and self-clearing sweep.
// Latency: rd_data/rd_valid READ_LAT (1 or 2) cycles after the accepting edge.
// Backpressure: none; user reads/writes are dropped while init_busy=1.
module inmf_sdp_buf
    import inmf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int READ_LAT  = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear,
    output logic              init_busy
);

    generate
        if (READ_LAT < RL_MIN || READ_LAT > RL_MAX) begin : g_bad_lat
            $error("inmf_sdp_buf: READ_LAT must be 1 or 2");
        end
        if (DATA_W < 1 || DATA_W > 72) begin : g_bad_w
            $error("inmf_sdp_buf: DATA_W must be 1..72");
        end
    endgenerate

    localparam inmf_buf_st_t ST_RST   = (INIT_ZERO != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    inmf_buf_st_t      state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              sweeping;
    logic              rd_acc;
    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_q;
    logic              v1;

    // Sweep FSM state and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: clear starts a sweep from 0; the sweep ends after the last address is written.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sweeping  = (state == ST_CLEAR);
    assign init_busy = sweeping;
    assign rd_acc    = rd_en && !sweeping;

    // The sweep owns the write port while busy; user writes are dropped then.
    assign core_we    = sweeping ? 1'b1 : wr_en;
    assign core_waddr = sweeping ? cnt  : wr_addr;
    assign core_wdata = sweeping ? '0   : wr_data;

    inmf_sdp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (rd_acc),
        .raddr (rd_addr),
        .q     (core_q)
    );

    // First valid stage tracks the registered array read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign rd_data  = core_q;
            assign rd_valid = v1;
        end else begin : g_lat2
            logic [DATA_W-1:0] out_q;
            logic              v2;

            // Output register stage; data only advances with a valid so it holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                    v2    <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        out_q <= core_q;
                    end
                end
            end

            assign rd_data  = out_q;
            assign rd_valid = v2;
        end
    endgenerate

endmodule

// File: tb/tb_inmf_sdp_buf.sv
// Testbench for inmf_sdp_buf: one instance per read latency, driven in lockstep.
// Latency: each read expectation carries the cycle it is due on.
// Backpressure: n/a.
module tb_inmf_sdp_buf;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en, clear;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_valid1, rd_valid2, busy1, busy2;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t          q1[$];
    exp_t          q2[$];
    logic [DW-1:0] mem_m [256];
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    int            n1, n2;

    inmf_sdp_buf #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .INIT_ZERO(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .clear(clear), .init_busy(busy1)
    );

    inmf_sdp_buf #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2), .INIT_ZERO(1)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .clear(clear), .init_busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the latency-1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && rd_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("rd1_spurious", 64'(rd_valid1), 64'd0);
            end else begin
                e = q1.pop_front();
                chk("rd1_data", 64'(rd_data1), 64'(e.d));
                chk("rd1_lat", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Scoreboard for the latency-2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && rd_valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("rd2_spurious", 64'(rd_valid2), 64'd0);
            end else begin
                e = q2.pop_front();
                chk("rd2_data", 64'(rd_data2), 64'(e.d));
                chk("rd2_lat", 64'(cyc), 64'(e.due));
            end
        end
    end

    // One clock of user traffic; reads push their expected data and due cycle.
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra);
        exp_t e;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (re) begin
            e.d   = (we && wa == ra) ? wd : mem_m[ra];
            e.due = cyc + 1;
            q1.push_back(e);
            e.due = cyc + 2;
            q2.push_back(e);
        end
        if (we) mem_m[wa] = wd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count busy cycles of both instances; optionally poke the user ports mid-sweep.
    task automatic measure(output int c1, output int c2, input bit poke);
        c1 = 0;
        c2 = 0;
        for (int it = 0; it < 2000 && (busy1 || busy2); it++) begin
            wr_en   = poke && it == 10;
            wr_addr = 8'h05;
            wr_data = 32'h0000AAAA;
            rd_en   = poke && it == 20;
            rd_addr = 8'h05;
            clear   = poke && it == 50;
            c1 += int'(busy1);
            c2 += int'(busy2);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic model_clear();
        foreach (mem_m[i]) mem_m[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        #3;
        chk("rst_valid1", 64'(rd_valid1), 64'd0);
        chk("rst_valid2", 64'(rd_valid2), 64'd0);
        chk("rst_data1", 64'(rd_data1), 64'd0);
        chk("rst_data2", 64'(rd_data2), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd1);
        chk("rst_busy2", 64'(busy2), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Power-up sweep length, then swept locations read back as zero.
        measure(n1, n2, 1'b0);
        chk("por_busy_len1", 64'(n1), 64'd256);
        chk("por_busy_len2", 64'(n2), 64'd256);
        model_clear();
        drive(1'b0, '0, '0, 1'b1, 8'h00);
        drive(1'b0, '0, '0, 1'b1, 8'h7F);
        drive(1'b0, '0, '0, 1'b1, 8'hFF);
        idle(3);

        // Write then read the next cycle.
        drive(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 8'h10);
        idle(3);

        // Same-cycle write and read of one address.
        drive(1'b1, 8'h20, 32'h12345678, 1'b1, 8'h20);
        idle(3);

        // Preload 0..15, then 16 back-to-back reads.
        for (int i = 0; i < 16; i++) drive(1'b1, AW'(i), 32'hA5000000 + DW'(i) * 32'h00010101, 1'b0, '0);
        for (int i = 0; i < 16; i++) drive(1'b0, '0, '0, 1'b1, AW'(i));
        idle(3);
        chk("hold_data1", 64'(rd_data1), 64'(mem_m[15]));
        chk("hold_data2", 64'(rd_data2), 64'(mem_m[15]));
        chk("hold_valid1", 64'(rd_valid1), 64'd0);

        // Clear sweep with a dropped write, dropped read and an ignored second clear.
        drive(1'b1, 8'h05, 32'h00001111, 1'b0, '0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        measure(n1, n2, 1'b1);
        chk("clr_busy_len1", 64'(n1), 64'd256);
        chk("clr_busy_len2", 64'(n2), 64'd256);
        model_clear();
        drive(1'b0, '0, '0, 1'b1, 8'h05);
        drive(1'b0, '0, '0, 1'b1, 8'h10);
        idle(3);

        // Reset in the middle of a sweep.
        drive(1'b1, 8'h33, 32'h5A5A5A5A, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 8'h33);
        idle(3);
        chk("pre_rst_data1", 64'(rd_data1), 64'h5A5A5A5A);
        chk("pre_rst_data2", 64'(rd_data2), 64'h5A5A5A5A);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        idle(100);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_data1", 64'(rd_data1), 64'd0);
        chk("mid_rst_data2", 64'(rd_data2), 64'd0);
        chk("mid_rst_valid1", 64'(rd_valid1), 64'd0);
        chk("mid_rst_valid2", 64'(rd_valid2), 64'd0);
        chk("mid_rst_busy1", 64'(busy1), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        measure(n1, n2, 1'b0);
        chk("rst_busy_len1", 64'(n1), 64'd256);
        chk("rst_busy_len2", 64'(n2), 64'd256);
        model_clear();
        drive(1'b0, '0, '0, 1'b1, 8'h33);
        idle(4);

        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
